// File: rtl/dem_updown_mod.sv
// dem_updown_mod: up/down counter with programmable modulus.
// Supports wrap or saturate at the boundaries, synchronous clear and load,
// and a count enable. tc is combinational so counters can be cascaded; ovf is
// a registered one-cycle pulse that marks every enabled boundary step.
module dem_updown_mod #(
   parameter int N       = 8,
   parameter int MAX_VAL = 2**N - 1,
   parameter int INIT    = 0
) (
   input  logic         clk,
   input  logic         reset,   // asynchronous, active low
   input  logic         en,
   input  logic         ud,      // 0 = up, 1 = down
   input  logic         mode,    // 0 = wrap, 1 = saturate
   input  logic         clr,
   input  logic         load,
   input  logic [N-1:0] d,
   output logic [N-1:0] q,
   output logic         tc,
   output logic         ovf
);

   // Comparisons are made one bit wider than the count. This keeps a load
   // value above MAX_VAL from wrapping around in an N-bit compare.
   localparam logic [N:0]   MAX_EXT  = (N+1)'(MAX_VAL);
   localparam logic [N-1:0] MAX_Q    = N'(MAX_VAL);
   localparam logic [N-1:0] INIT_Q   = N'(INIT);
   localparam logic [N-1:0] ZERO_Q   = '0;
   localparam logic [N-1:0] ONE_Q    = N'(1);

   logic [N-1:0] q_q,   q_d;
   logic         ovf_q, ovf_d;
   logic [N:0]   q_ext;
   logic [N:0]   d_ext;
   logic         at_max;
   logic         at_zero;

   assign q_ext   = {1'b0, q_q};
   assign d_ext   = {1'b0, d};
   assign at_max  = (q_ext >= MAX_EXT);
   assign at_zero = (q_q == ZERO_Q);

   // Next-state logic. clr has priority over load, load over en, and en over hold.
   always_comb begin
      q_d   = q_q;
      ovf_d = 1'b0;
      if (clr) begin
         q_d = ZERO_Q;
      end else if (load) begin
         q_d = (d_ext > MAX_EXT) ? MAX_Q : d;
      end else if (en) begin
         if (!ud) begin
            if (!at_max) begin
               // Cannot overflow N bits: q is strictly below MAX_VAL here
               q_d = q_q + ONE_Q;
            end else begin
               q_d   = mode ? MAX_Q : ZERO_Q;
               ovf_d = 1'b1;
            end
         end else begin
            if (!at_zero) begin
               q_d = q_q - ONE_Q;
            end else begin
               q_d   = mode ? ZERO_Q : MAX_Q;
               ovf_d = 1'b1;
            end
         end
      end
   end

   // Count and boundary-pulse registers. Reset also cancels any pending ovf.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_q   <= INIT_Q;
         ovf_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         ovf_q <= ovf_d;
      end
   end

   // Terminal count follows ud directly, so a cascaded digit sees the carry
   // on the same edge that this digit wraps.
   assign tc  = ud ? at_zero : at_max;
   assign q   = q_q;
   assign ovf = ovf_q;

endmodule

// File: tb/tb_dem_updown_mod.sv
module tb_dem_updown_mod;

   logic       clk = 1'b0;
   logic       reset;
   logic       en, ud, mode, clr, load;
   logic [7:0] d;
   logic [7:0] q;
   logic       tc, ovf;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string      name;
      logic [7:0] q;
      logic       ovf;
      logic       tc;
   } exp_t;

   exp_t exp_q[$];

   dem_updown_mod #(.N(8), .MAX_VAL(9), .INIT(0)) dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .ud    (ud),
      .mode  (mode),
      .clr   (clr),
      .load  (load),
      .d     (d),
      .q     (q),
      .tc    (tc),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   // Monitor: after each edge the outputs are stable on the falling edge;
   // pop the expectation pushed for that edge and compare.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_tests++;
         if (q !== e.q || ovf !== e.ovf || tc !== e.tc) begin
            n_fail++;
            $display("[TB] FAIL %s: got q=%0d ovf=%0b tc=%0b, expected q=%0d ovf=%0b tc=%0b",
                     e.name, q, ovf, tc, e.q, e.ovf, e.tc);
         end else begin
            $display("[TB] %s: q=%0d ovf=%0b tc=%0b ok", e.name, q, ovf, tc);
         end
      end
   end

   // Drive one cycle of inputs after the falling edge, then queue the
   // hand-computed result expected after the following rising edge.
   task automatic cyc(input string nm, input logic rs, input logic e, input logic u,
                      input logic m, input logic c, input logic l, input logic [7:0] dv,
                      input logic [7:0] eq, input logic eo, input logic et);
      exp_t x;
      @(negedge clk);
      #1;
      reset = rs; en = e; ud = u; mode = m; clr = c; load = l; d = dv;
      @(posedge clk);
      x.name = nm; x.q = eq; x.ovf = eo; x.tc = et;
      exp_q.push_back(x);
   endtask

   // Immediate comparison for asynchronous behaviour between edges.
   task automatic check_now(input string nm, input logic [7:0] eq, input logic eo);
      n_tests++;
      if (q !== eq || ovf !== eo) begin
         n_fail++;
         $display("[TB] FAIL %s: got q=%0d ovf=%0b, expected q=%0d ovf=%0b", nm, q, ovf, eq, eo);
      end else begin
         $display("[TB] %s: q=%0d ovf=%0b ok", nm, q, ovf);
      end
   endtask

   // Pull reset low in the middle of a cycle with en active.
   task automatic mid_reset(input string nm);
      @(negedge clk);
      #1;
      en = 1'b1; ud = 1'b0; mode = 1'b0; clr = 1'b0; load = 1'b0;
      reset = 1'b0;
      #1;
      check_now(nm, 8'd0, 1'b0);
   endtask

   logic [7:0] up_seq [10] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0};

   initial begin
      reset = 1'b0; en = 1'b0; ud = 1'b0; mode = 1'b0; clr = 1'b0; load = 1'b0; d = 8'd0;
      #3;
      check_now("reset_state", 8'd0, 1'b0);
      n_tests++;
      if (tc !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_tc: got tc=%0b, expected tc=0", tc);
      end

      // 1: count up 0..9 then wrap to 0 with ovf on the wrap edge only
      for (int i = 0; i < 10; i++)
         cyc("up_count", 1, 1, 0, 0, 0, 0, 8'd0, up_seq[i], (i == 9), (up_seq[i] == 8'd9));
      cyc("up_after_wrap", 1, 1, 0, 0, 0, 0, 8'd0, 8'd1, 0, 0);

      // 2: down wrap from 0 to MAX_VAL, then a plain decrement
      cyc("clr_to_zero", 1, 0, 0, 0, 1, 0, 8'd0, 8'd0, 0, 0);
      cyc("down_wrap", 1, 1, 1, 0, 0, 0, 8'd0, 8'd9, 1, 0);
      cyc("down_step", 1, 1, 1, 0, 0, 0, 8'd0, 8'd8, 0, 0);

      // 3: saturate at the top for three edges, then step down
      cyc("load_9", 1, 0, 0, 1, 0, 1, 8'd9, 8'd9, 0, 1);
      for (int i = 0; i < 3; i++)
         cyc("sat_up_hold", 1, 1, 0, 1, 0, 0, 8'd0, 8'd9, 1, 1);
      cyc("sat_then_down", 1, 1, 1, 1, 0, 0, 8'd0, 8'd8, 0, 0);
      cyc("clr_for_sat_dn", 1, 0, 1, 1, 1, 0, 8'd0, 8'd0, 0, 1);
      cyc("sat_down_hold", 1, 1, 1, 1, 0, 0, 8'd0, 8'd0, 1, 1);

      // 4: load clamping and priorities
      cyc("load_clamp_200", 1, 1, 0, 0, 0, 1, 8'd200, 8'd9, 0, 1);
      cyc("clr_beats_load", 1, 1, 0, 0, 1, 1, 8'd5, 8'd0, 0, 0);
      cyc("load_7", 1, 1, 1, 0, 0, 1, 8'd7, 8'd7, 0, 0);
      cyc("load_clamp_255", 1, 0, 0, 0, 0, 1, 8'd255, 8'd9, 0, 1);
      cyc("load_10", 1, 0, 1, 0, 0, 1, 8'd10, 8'd9, 0, 0);

      // 5: asynchronous reset mid-count at q=5
      cyc("load_5", 1, 0, 0, 0, 0, 1, 8'd5, 8'd5, 0, 0);
      mid_reset("async_reset_q5");
      cyc("reset_hold_1", 0, 1, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0);
      cyc("reset_hold_2", 0, 1, 0, 0, 0, 0, 8'd0, 8'd0, 0, 0);
      cyc("resume_count", 1, 1, 0, 0, 0, 0, 8'd0, 8'd1, 0, 0);
      // reset aborts a pending ovf pulse
      cyc("load_9_again", 1, 0, 0, 0, 0, 1, 8'd9, 8'd9, 0, 1);
      cyc("wrap_for_abort", 1, 1, 0, 0, 0, 0, 8'd0, 8'd0, 1, 0);
      mid_reset("async_reset_ovf");
      cyc("resume_after_abort", 1, 1, 0, 0, 0, 0, 8'd0, 8'd1, 0, 0);

      // 6: en low, ud and mode toggling: q holds, tc follows ud
      cyc("clr_idle", 1, 0, 0, 0, 1, 0, 8'd0, 8'd0, 0, 0);
      for (int i = 0; i < 20; i++)
         cyc("idle_hold", 1, 0, logic'(i % 2), logic'((i / 2) % 2), 0, 0, 8'd0, 8'd0, 0,
             logic'(i % 2));

      // let the monitor drain, bounded
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: got no finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
